// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and widths for the pipeline hazard controller.
package pipe_ctrl_pkg;
    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;
    typedef enum logic {RUN, MEM_WAIT} state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between the load in EX and the sources in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_reg_addr,
    output logic                  load_use
);
    // $0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_write_reg_addr != '0) &&
                      (ex_write_reg_addr == rs_addr || ex_write_reg_addr == rt_addr);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for a 5-stage pipeline with a variable-latency data memory.
// Priority: memory stall > taken branch > load-use bubble.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  id_rs_addr,
    input  logic [REG_ADDR_W-1:0]  id_rt_addr,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_write_reg_addr,
    input  logic                   mem_branch,
    input  logic                   mem_alu_zero,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic                   dmem_ack,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   dmem_req,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    state_t     state, next_state;
    logic [4:0] en;
    logic [2:0] flush;
    logic       load_use;
    logic       branch_taken;

    assign branch_taken = mem_branch && mem_alu_zero;

    hazard_detect u_hazard_detect (
        .rs_addr           (id_rs_addr),
        .rt_addr           (id_rt_addr),
        .ex_mem_read       (ex_mem_read),
        .ex_write_reg_addr (ex_write_reg_addr),
        .load_use          (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        en         = '1;
        flush      = '0;
        dmem_req   = 1'b0;
        if (rst) begin
            next_state = RUN;
            en         = '0;
            flush      = '1;
        end else if (state == MEM_WAIT) begin
            dmem_req   = 1'b1;
            en         = {5{dmem_ack}};
            next_state = dmem_ack ? RUN : MEM_WAIT;
        end else begin
            dmem_req = mem_read || mem_write;
            if (dmem_req && !dmem_ack) begin
                en         = '0;
                next_state = MEM_WAIT;
            end else if (branch_taken) begin
                flush = '1;
            end else if (load_use) begin
                en[4:3]  = 2'b00;
                flush[1] = 1'b1;
            end
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en;
    assign {ifid_flush, idex_flush, exmem_flush}         = flush;

    // Counts frozen-PC cycles; holds at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               stall_cycles <= '0;
        else if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
endmodule
